// File: rtl/data_crypt_pkg.sv
// -----------------------------------------------------------------------------
// data_crypt_pkg
// Constants and helpers shared by data_encrypt and data_decrypt. Both sides of
// the serial link take their defaults from here so the scrambler and the
// descrambler always use the same polynomial.
//   CRYPT_WIDTH     : history register length (polynomial degree)
//   CRYPT_TAPS      : feedback mask, bit k = code bit from k+1 cycles ago
//   CRYPT_SEED      : history value loaded on reset
//   crypt_feedback  : XOR-reduced parity of (history & taps)
// -----------------------------------------------------------------------------
package data_crypt_pkg;

    localparam int unsigned CRYPT_MAX_WIDTH = 32;
    localparam int unsigned CRYPT_WIDTH     = 7;

    // x^7 + x^4 + 1: code[n] = d[n] ^ code[n-4] ^ code[n-7]
    localparam logic [CRYPT_WIDTH-1:0] CRYPT_TAPS = 7'b1001000;
    localparam logic [CRYPT_WIDTH-1:0] CRYPT_SEED = '0;

    // Arguments are zero-extended to the widest legal history so one function
    // serves every WIDTH; unused upper tap bits are zero and drop out.
    function automatic logic crypt_feedback(
        input logic [CRYPT_MAX_WIDTH-1:0] history,
        input logic [CRYPT_MAX_WIDTH-1:0] taps
    );
        return ^(history & taps);
    endfunction

endpackage

// File: rtl/crypt_shift_reg.sv
// -----------------------------------------------------------------------------
// crypt_shift_reg
// WIDTH-bit serial-in history register for the scrambler/descrambler pair.
// Bit 0 holds the most recently shifted bit. A synchronous reset loads SEED.
//   i_clk   in  1      clock, rising edge
//   i_rst   in  1      synchronous active-high reset (loads SEED)
//   i_bit   in  1      bit shifted in at bit 0 on every non-reset edge
//   o_hist  out WIDTH  current history, o_hist[k] = bit from k+1 edges ago
// -----------------------------------------------------------------------------
module crypt_shift_reg
    import data_crypt_pkg::*;
#(
    parameter int unsigned      WIDTH = CRYPT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRYPT_SEED)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_hist
);

    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= SEED;
        end else begin
            r_hist <= {r_hist[WIDTH-2:0], i_bit};
        end
    end

    assign o_hist = r_hist;

endmodule

// File: rtl/data_decrypt.sv
// -----------------------------------------------------------------------------
// data_decrypt
// Receive-side descrambler matching data_encrypt. Received code bits feed the
// history directly, so after WIDTH bits the history matches the transmitter's
// regardless of either side's start state and the plaintext is recovered.
//   WIDTH   history length, 2..32
//   TAPS    feedback mask, must equal the transmitter's
//   SEED    history value loaded on reset (need not match the transmitter)
//   i_clk   in  1  clock, rising edge
//   i_rst   in  1  synchronous active-high reset
//   i_code  in  1  received code bit, sampled every rising edge
//   o_data  out 1  registered recovered plaintext bit, 0 after a reset edge
// -----------------------------------------------------------------------------
module data_decrypt
    import data_crypt_pkg::*;
#(
    parameter int unsigned      WIDTH = CRYPT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(CRYPT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRYPT_SEED)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_code,
    output logic o_data
);

    localparam logic [CRYPT_MAX_WIDTH-1:0] TAPS_EXT = CRYPT_MAX_WIDTH'(TAPS);

    logic [WIDTH-1:0]           w_hist;
    logic [CRYPT_MAX_WIDTH-1:0] w_hist_ext;
    logic                       w_fb;
    logic                       r_data;

    crypt_shift_reg #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_hist (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_bit  (i_code),
        .o_hist (w_hist)
    );

    assign w_hist_ext = CRYPT_MAX_WIDTH'(w_hist);
    assign w_fb       = crypt_feedback(w_hist_ext, TAPS_EXT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= 1'b0;
        end else begin
            r_data <= i_code ^ w_fb;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/data_encrypt.sv
// -----------------------------------------------------------------------------
// data_encrypt
// Self-synchronizing (multiplicative) scrambler. Each plaintext bit is XORed
// with the parity of tapped earlier code bits; the code bit is registered on
// o_code and also shifted into the history. One code bit per clock, no enable.
//   WIDTH   history length, 2..32
//   TAPS    feedback mask, bit k = code bit from k+1 cycles ago
//   SEED    history value loaded on reset
//   i_clk   in  1  clock, rising edge
//   i_rst   in  1  synchronous active-high reset; i_data ignored that edge
//   i_data  in  1  plaintext bit, sampled every rising edge
//   o_code  out 1  registered code bit, 0 after a reset edge
// -----------------------------------------------------------------------------
module data_encrypt
    import data_crypt_pkg::*;
#(
    parameter int unsigned      WIDTH = CRYPT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(CRYPT_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRYPT_SEED)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_data,
    output logic o_code
);

    localparam logic [CRYPT_MAX_WIDTH-1:0] TAPS_EXT = CRYPT_MAX_WIDTH'(TAPS);

    logic [WIDTH-1:0]           w_hist;
    logic [CRYPT_MAX_WIDTH-1:0] w_hist_ext;
    logic                       w_fb;
    logic                       w_code;
    logic                       r_code;

    crypt_shift_reg #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_hist (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_bit  (w_code),
        .o_hist (w_hist)
    );

    assign w_hist_ext = CRYPT_MAX_WIDTH'(w_hist);
    assign w_fb       = crypt_feedback(w_hist_ext, TAPS_EXT);
    assign w_code     = i_data ^ w_fb;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code <= 1'b0;
        end else begin
            r_code <= w_code;
        end
    end

    assign o_code = r_code;

endmodule

// File: tb/tb_data_encrypt.sv
// -----------------------------------------------------------------------------
// tb_data_encrypt
// Bench for data_encrypt: a default-seed instance, a SEED=7'h7F instance and a
// data_decrypt loopback fed from the default instance. A reference model keeps
// the produced code bits as a time series and applies
// code[n] = d[n] ^ XOR over set taps k of code[n-k-1], with pre-reset history
// taken from SEED.
// -----------------------------------------------------------------------------
module tb_data_encrypt;

    localparam int unsigned W        = 7;
    localparam logic [W-1:0] M_TAPS  = 7'b1001000;
    localparam logic [W-1:0] SEED_A  = 7'h00;
    localparam logic [W-1:0] SEED_B  = 7'h7F;
    localparam logic [W-1:0] SEED_RX = 7'h55;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic code_a;
    logic code_b;
    logic dec_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_encrypt u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (din),
        .o_code (code_a)
    );

    data_encrypt #(
        .SEED (SEED_B)
    ) u_seed (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_data (din),
        .o_code (code_b)
    );

    data_decrypt #(
        .SEED (SEED_RX)
    ) u_dec (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_code (code_a),
        .o_data (dec_out)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // Parity of tapped past code bits; j cycles back either comes from the
    // recorded series or, before the last reset, from the seed.
    function automatic logic model_fb(input logic q[$], input logic [W-1:0] seed);
        logic p;
        int   n;
        int   j;
        p = 1'b0;
        n = q.size();
        for (int k = 0; k < int'(W); k++) begin
            if (M_TAPS[k]) begin
                j = k + 1;
                if (j <= n) p = p ^ q[n - j];
                else        p = p ^ seed[j - n - 1];
            end
        end
        return p;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    logic q_a[$];
    logic q_b[$];
    logic exp_a;
    logic exp_b;
    logic s_rst;
    logic s_din;
    logic prev_d;
    int   since_rst = 0;

    always @(posedge clk) begin
        s_rst = rst;
        s_din = din;
        #1;
        if (s_rst) begin
            q_a.delete();
            q_b.delete();
            since_rst = 0;
            check("rst_code_a", code_a, 1'b0);
            check("rst_code_b", code_b, 1'b0);
            check("rst_dec", dec_out, 1'b0);
        end else begin
            exp_a = s_din ^ model_fb(q_a, SEED_A);
            exp_b = s_din ^ model_fb(q_b, SEED_B);
            q_a.push_back(exp_a);
            q_b.push_back(exp_b);
            if (q_a.size() > int'(W)) void'(q_a.pop_front());
            if (q_b.size() > int'(W)) void'(q_b.pop_front());
            check("model_code_a", code_a, exp_a);
            check("model_code_b", code_b, exp_b);
            // Decrypted bit after edge m is d[m-1], valid once 7 real code
            // bits fill the receiver history.
            if (since_rst >= 8) check("loopback", dec_out, prev_d);
            prev_d = s_din;
            since_rst++;
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    task automatic step(input logic r, input logic d);
        @(negedge clk);
        rst = r;
        din = d;
        @(posedge clk);
        #2;
    endtask

    logic [11:0] imp_exp;
    logic [8:0]  idle_exp;
    logic        d0;

    initial begin
        imp_exp  = 12'b0001_1001_0001;  // bit i = code i: 1,0,0,0,1,0,0,1,1,0,0,0
        idle_exp = 9'b1_0111_0000;      // 0,0,0,0,1,1,1,0,1

        // reset held with random data
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)));
        d0 = 1'($urandom_range(0, 1));
        step(1'b0, d0);
        check("first_out", code_a, d0);

        // impulse through the default (SEED=0) instance
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i == 0) ? 1'b1 : 1'b0);
            check($sformatf("impulse[%0d]", i), code_a, imp_exp[i]);
        end

        // all-zero input through the SEED=7'h7F instance
        step(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("seed_idle[%0d]", i), code_b, idle_exp[i]);
        end

        // long random stream
        step(1'b1, 1'b0);
        for (int i = 0; i < 10000; i++) step(1'b0, 1'($urandom_range(0, 1)));

        // mid-stream single-cycle reset
        step(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b1, 1'b1);
        check("midrst_zero", code_a, 1'b0);
        d0 = 1'($urandom_range(0, 1));
        step(1'b0, d0);
        check("midrst_first", code_a, d0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'($urandom_range(0, 1)));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
